// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin scheduler granting up to two register-file writes per cycle,
// never pairing two different writes to the same register in one cycle.
module regfile_write_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [4*NREQ-1:0]         req_reg,
    input  logic [DATAWIDTH*NREQ-1:0] req_data,
    input  logic                      hold,
    output logic                      wr_en,
    output logic [3:0]                wr_reg1,
    output logic [3:0]                wr_reg2,
    output logic [DATAWIDTH-1:0]      wr_data1,
    output logic [DATAWIDTH-1:0]      wr_data2,
    output logic [CNTW-1:0]           conflict_cnt
);
    localparam int PW = $clog2(NREQ);

    logic [3:0]           regs  [NREQ];
    logic [DATAWIDTH-1:0] datas [NREQ];
    logic [PW-1:0]        rr_ptr, idx, g1, g2, last;
    logic                 g1_found, g2_found, defer;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign regs[i]  = req_reg[4*i +: 4];
        assign datas[i] = req_data[DATAWIDTH*i +: DATAWIDTH];
    end

    // Scan from rr_ptr; same-register requests met before G2 are deferred to a later cycle.
    always_comb begin
        req_ready = '0;
        g1_found = 1'b0;
        g2_found = 1'b0;
        defer = 1'b0;
        g1 = '0;
        g2 = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (resetn && !hold && req_valid[idx]) begin
                if (!g1_found) begin
                    g1_found = 1'b1;
                    g1 = idx;
                    req_ready[idx] = 1'b1;
                end else if (!g2_found && regs[idx] == regs[g1]) begin
                    defer = 1'b1;
                end else if (!g2_found) begin
                    g2_found = 1'b1;
                    g2 = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    assign last = g2_found ? g2 : g1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_en <= 1'b0;
            wr_reg1 <= '0;
            wr_reg2 <= '0;
            wr_data1 <= '0;
            wr_data2 <= '0;
            rr_ptr <= '0;
            conflict_cnt <= '0;
        end else begin
            wr_en <= g1_found;
            if (g1_found) begin
                wr_reg1 <= regs[g1];
                wr_data1 <= datas[g1];
                wr_reg2 <= g2_found ? regs[g2] : regs[g1];
                wr_data2 <= g2_found ? datas[g2] : datas[g1];
                rr_ptr <= (last == PW'(NREQ - 1)) ? '0 : last + 1'b1;
            end
            if (defer && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scoreboard bench; expected issue-stage values are queued
// when a request pattern is driven and checked after the following clock edge.
module tb_regfile_write_arbiter;
    localparam int CNTW = 4;

    logic         clk = 1'b0;
    logic         resetn, hold, wr_en;
    logic [3:0]   req_valid, req_ready, wr_reg1, wr_reg2;
    logic [15:0]  req_reg;
    logic [127:0] req_data;
    logic [31:0]  wr_data1, wr_data2;
    logic [CNTW-1:0] conflict_cnt;

    typedef struct packed {
        logic            en;
        logic [3:0]      r1, r2;
        logic [31:0]     d1, d2;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  er1 = '0, er2 = '0;
    logic [31:0] ed1 = '0, ed2 = '0;

    regfile_write_arbiter #(.DATAWIDTH(32), .NREQ(4), .CNTW(CNTW)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_reg(req_reg), .req_data(req_data), .hold(hold), .wr_en(wr_en),
        .wr_reg1(wr_reg1), .wr_reg2(wr_reg2), .wr_data1(wr_data1), .wr_data2(wr_data2),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set(input logic [3:0] v, input logic [15:0] r, input logic [127:0] d);
        req_valid = v;
        req_reg = r;
        req_data = d;
    endtask

    task automatic tick(input logic [3:0] rdy, input logic en, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [CNTW-1:0] cnt);
        exp_t e;
        #1;
        chk("req_ready", 32'(req_ready), 32'(rdy));
        if (!resetn) begin
            er1 = '0; er2 = '0; ed1 = '0; ed2 = '0;
        end else if (en) begin
            er1 = r1; er2 = r2; ed1 = d1; ed2 = d2;
        end
        sb.push_back('{en, er1, er2, ed1, ed2, cnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wr_en", 32'(wr_en), 32'(e.en));
        chk("wr_reg1", 32'(wr_reg1), 32'(e.r1));
        chk("wr_reg2", 32'(wr_reg2), 32'(e.r2));
        chk("wr_data1", wr_data1, e.d1);
        chk("wr_data2", wr_data2, e.d2);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        hold = 1'b0;
        set(4'b1111, 16'h4321, {32'h103, 32'h102, 32'h101, 32'h100});
        tick(4'b0000, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'd0);
        tick(4'b0000, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'd0);
        resetn = 1'b1;
        set(4'b0000, 16'h0, 128'h0);
        repeat (3) tick(4'b0000, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'd0);
        set(4'b0101, 16'h0703, {32'h0, 32'hB, 32'h0, 32'hA});
        tick(4'b0101, 1'b1, 4'h3, 4'h7, 32'hA, 32'hB, 4'd0);
        set(4'b0001, 16'h0001, {96'h0, 32'h1});
        tick(4'b0001, 1'b1, 4'h1, 4'h1, 32'h1, 32'h1, 4'd0);
        set(4'b0110, 16'h0550, {32'h0, 32'h22, 32'h11, 32'h0});
        tick(4'b0010, 1'b1, 4'h5, 4'h5, 32'h11, 32'h11, 4'd1);
        set(4'b0100, 16'h0550, {32'h0, 32'h22, 32'h11, 32'h0});
        tick(4'b0100, 1'b1, 4'h5, 4'h5, 32'h22, 32'h22, 4'd1);
        set(4'b0000, 16'h0, 128'h0);
        tick(4'b0000, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'd1);
        set(4'b1000, 16'h9000, {32'h9, 96'h0});
        tick(4'b1000, 1'b1, 4'h9, 4'h9, 32'h9, 32'h9, 4'd1);
        set(4'b1111, 16'h4321, {32'h103, 32'h102, 32'h101, 32'h100});
        tick(4'b0011, 1'b1, 4'h1, 4'h2, 32'h100, 32'h101, 4'd1);
        tick(4'b1100, 1'b1, 4'h3, 4'h4, 32'h102, 32'h103, 4'd1);
        tick(4'b0011, 1'b1, 4'h1, 4'h2, 32'h100, 32'h101, 4'd1);
        hold = 1'b1;
        repeat (2) tick(4'b0000, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'd1);
        hold = 1'b0;
        tick(4'b1100, 1'b1, 4'h3, 4'h4, 32'h102, 32'h103, 4'd1);
        tick(4'b0011, 1'b1, 4'h1, 4'h2, 32'h100, 32'h101, 4'd1);
        resetn = 1'b0;
        tick(4'b0000, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'd0);
        resetn = 1'b1;
        tick(4'b0011, 1'b1, 4'h1, 4'h2, 32'h100, 32'h101, 4'd0);
        set(4'b0011, 16'h0055, {64'h0, 32'h51, 32'h50});
        for (int i = 1; i <= 17; i++) begin
            if (i % 2 == 1)
                tick(4'b0001, 1'b1, 4'h5, 4'h5, 32'h50, 32'h50, (i < 15) ? CNTW'(i) : '1);
            else
                tick(4'b0010, 1'b1, 4'h5, 4'h5, 32'h51, 32'h51, (i < 15) ? CNTW'(i) : '1);
        end
        set(4'b0000, 16'h0, 128'h0);
        tick(4'b0000, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, '1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Round-robin write scheduler in front of the 16-entry, dual-write-port register file.
- Accepts register write requests from NREQ independent requesters using valid/ready.
- Grants up to two requests per cycle and drives the register file's write ports from a registered issue stage: write enable, two register indices and two data words.
- Guarantees the register file never sees two different values written to the same register in one cycle.

Parameters:
- DATAWIDTH, 32: width of write data.
- NREQ, 4: number of requesters (2..8).
- CNTW, 16: width of the saturating conflict counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  input  NREQ  per-requester write request valid.
- req_ready  output  NREQ  per-requester grant; a transfer happens when valid and ready are both 1.
- req_reg  input  4*NREQ  target register index; requester i uses bits [4i+3:4i].
- req_data  input  DATAWIDTH*NREQ  write data; requester i uses slice i.
- hold  input  1  when 1, no grants are issued.
- wr_en  output  1  register file write enable.
- wr_reg1  output  4  register file write port 1 index.
- wr_reg2  output  4  register file write port 2 index.
- wr_data1  output  DATAWIDTH  register file write port 1 data.
- wr_data2  output  DATAWIDTH  register file write port 2 data.
- conflict_cnt  output  CNTW  saturating count of same-register deferrals.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - wr_en=0; wr_reg1=wr_reg2=0; wr_data1=wr_data2=0.
  - Round-robin pointer rr_ptr=0; conflict_cnt=0.
  - Asynchronous resetn changes have no effect until the next edge.
  - Reset mid-operation discards the issue stage. Requests presented in the reset cycle are not granted (req_ready=0 while resetn=0).
- req_ready is combinational from req_valid, req_reg, rr_ptr, hold and resetn. req_ready is 1 only where req_valid is 1.
- Grant selection each cycle, when hold=0 and resetn=1:
  - Scan requesters in order rr_ptr, rr_ptr+1, ... modulo NREQ.
  - First grant G1: the first valid requester.
  - Second grant G2: the next valid requester after G1 whose req_reg differs from G1's req_reg.
  - Valid requesters skipped because their req_reg equals G1's are deferred and not granted this cycle.
  - conflict_cnt increments by 1 (saturating at all-ones) in any cycle with at least one such deferral, even if a G2 was found later in the scan.
- Issue stage, registered with one cycle latency from a granted handshake to wr_en:
  - Two grants: wr_en=1, wr_reg1/wr_data1 from G1, wr_reg2/wr_data2 from G2.
  - One grant: wr_en=1, and both ports carry G1's reg and data, so the duplicate write is identical.
  - No grant (no valid requests, or hold=1): wr_en=0; wr_reg/wr_data hold their previous values.
- rr_ptr update:
  - After a cycle with grants, rr_ptr = (index of last grant + 1) mod NREQ.
  - Unchanged when there are no grants.
  - This yields fairness: any continuously valid requester is granted within ceil(NREQ/2) cycles absent conflicts, and within NREQ cycles with conflicts.
- Requester obligations:
  - Hold req_valid, req_reg and req_data stable until granted.
  - The arbiter does not check these; the bench asserts them.
- hold:
  - Takes effect in the same cycle: req_ready=0.
  - The issue stage still registers wr_en=0 in the next cycle.
- Write ordering between different requesters to the same register follows grant order. A deferred request is always granted in a strictly later cycle.

Test Plan:
- Reset, then all req_valid=0 for 3 cycles -> wr_en=0, conflict_cnt=0, req_ready=0000.
- Requesters 0 and 2 valid (reg 3, data 0xA; reg 7, data 0xB), rr_ptr=0 -> req_ready=0101. Next cycle: wr_en=1, wr_reg1=3, wr_data1=0xA, wr_reg2=7, wr_data2=0xB. rr_ptr becomes 3.
- Requesters 1 and 2 both valid targeting reg 5 (data 0x11, 0x22), rr_ptr=1 -> cycle 1 grants only requester 1: wr_reg1=wr_reg2=5, data 0x11, conflict_cnt=1. Cycle 2 grants requester 2: data 0x22. Register 5 ends at 0x22.
- All 4 requesters continuously valid with distinct regs -> grants alternate {0,1} then {2,3} then {0,1}, with wr_en=1 every cycle.
- hold=1 for 2 cycles with requests pending -> req_ready=0000 and wr_en=0. After hold drops, the pending requests are granted in rr order.
- resetn=0 asserted mid-stream while wr_en=1 -> next edge: wr_en=0, rr_ptr=0, conflict_cnt=0. Requests resume from requester 0 after release. Also force 2^CNTW+1 conflicts -> conflict_cnt saturates at all-ones.
